// File: rtl/bel_twiddle_gen.sv
// Twiddle-factor generator for the FFT complex multiplier: one butterfly-stage sequence
// per start, Q1.(word_width-1) values from a quarter-wave sine ROM, frozen by pipe_halt.
module bel_twiddle_gen #(
    parameter int unsigned word_width = 16,
    parameter int unsigned max_log2   = 10
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic                  pipe_halt,
    input  logic                  start_i,
    input  logic [3:0]            log2_n_i,
    input  logic [3:0]            stride_log2_i,
    input  logic                  inverse_i,
    output logic [word_width-1:0] tw_re_o,
    output logic [word_width-1:0] tw_im_o,
    output logic                  tw_valid_o,
    output logic                  busy_o,
    output logic                  done_o
);

    localparam int unsigned W    = word_width;
    localparam int unsigned MW   = max_log2;
    localparam int unsigned AW   = max_log2 - 1;
    localparam int unsigned Q    = 1 << (max_log2 - 2);
    localparam int unsigned NMAX = 1 << max_log2;
    localparam longint      AMP  = (longint'(1) << (W - 1)) - 1;

    // sin(th) with th and result in Q30, Taylor series on [0, pi/2]
    function automatic longint sin_q30(input longint th);
        longint x2;
        longint term;
        longint acc;
        x2   = (th * th) >>> 30;
        term = th;
        acc  = th;
        for (int n = 1; n <= 12; n++) begin
            term = -(((term * x2) >>> 30) / longint'((2 * n) * (2 * n + 1)));
            acc  = acc + term;
        end
        return acc;
    endfunction

    // Top entry pinned to +max so negation can never overflow
    function automatic logic [W-1:0] rom_val(input int unsigned idx);
        longint th;
        longint v;
        if (idx >= Q) return W'(AMP);
        th = (64'sd6746518852 * longint'(idx)) / longint'(NMAX);
        v  = (sin_q30(th) * AMP + (longint'(1) <<< 29)) >>> 30;
        return W'(v);
    endfunction

    logic [W-1:0] w_rom [0:Q];

    for (genvar g = 0; g <= int'(Q); g++) begin : g_rom
        localparam logic [W-1:0] ROM_V = rom_val(g);
        assign w_rom[g] = ROM_V;
    end

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t              r_state;
    logic [MW-1:0]       r_k;
    logic [MW-1:0]       r_step;
    logic [MW-1:0]       r_cnt;
    logic [MW-1:0]       r_m;
    logic [3:0]          r_shift;
    logic                r_inv;
    logic                r_v0;
    logic                r_last0;
    logic                r_v1;
    logic                r_last1;
    logic signed [W-1:0] r_cos;
    logic signed [W-1:0] r_sin;

    logic [MW-1:0]       w_cnt_init;
    logic [MW-1:0]       w_step;
    logic [3:0]          w_shift;
    logic                w_hi;
    logic [AW-1:0]       w_mp;
    logic [AW-1:0]       w_cos_idx;
    logic [AW-1:0]       w_sin_idx;
    logic signed [W-1:0] w_cos;
    logic signed [W-1:0] w_sin;

    // Sequence parameters derived from the start request
    always_comb begin
        w_step  = MW'(1) << stride_log2_i;
        w_shift = 4'(MW) - log2_n_i;
        if (stride_log2_i >= log2_n_i - 4'd1) begin
            w_cnt_init = MW'(1);
        end else begin
            w_cnt_init = MW'(1) << (log2_n_i - 4'd1 - stride_log2_i);
        end
    end

    // Quadrant fold: second quadrant reuses the ROM mirrored, with cos negated
    always_comb begin
        w_hi = r_m > MW'(Q);
        w_mp = AW'(r_m - MW'(Q));
        if (w_hi) begin
            w_cos_idx = w_mp;
            w_sin_idx = AW'(Q) - w_mp;
        end else begin
            w_cos_idx = AW'(Q) - AW'(r_m);
            w_sin_idx = AW'(r_m);
        end
        w_cos = w_hi ? -$signed(w_rom[w_cos_idx]) : $signed(w_rom[w_cos_idx]);
        w_sin = $signed(w_rom[w_sin_idx]);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state    <= ST_IDLE;
            r_k        <= '0;
            r_step     <= '0;
            r_cnt      <= '0;
            r_m        <= '0;
            r_shift    <= '0;
            r_inv      <= 1'b0;
            r_v0       <= 1'b0;
            r_last0    <= 1'b0;
            r_v1       <= 1'b0;
            r_last1    <= 1'b0;
            r_cos      <= '0;
            r_sin      <= '0;
            tw_re_o    <= '0;
            tw_im_o    <= '0;
            tw_valid_o <= 1'b0;
            busy_o     <= 1'b0;
            done_o     <= 1'b0;
        end else if (!pipe_halt) begin
            r_v0    <= 1'b0;
            r_last0 <= 1'b0;
            if (done_o) busy_o <= 1'b0;

            case (r_state)
                ST_IDLE: begin
                    if (start_i && !busy_o) begin
                        r_state <= ST_RUN;
                        r_k     <= '0;
                        r_step  <= w_step;
                        r_cnt   <= w_cnt_init;
                        r_shift <= w_shift;
                        r_inv   <= inverse_i;
                        busy_o  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    r_m     <= r_k << r_shift;
                    r_v0    <= 1'b1;
                    r_last0 <= (r_cnt == MW'(1));
                    r_k     <= r_k + r_step;
                    r_cnt   <= r_cnt - MW'(1);
                    if (r_cnt == MW'(1)) r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase

            r_v1    <= r_v0;
            r_last1 <= r_v0 & r_last0;
            if (r_v0) begin
                r_cos <= w_cos;
                r_sin <= w_sin;
            end

            tw_valid_o <= r_v1;
            done_o     <= r_v1 & r_last1;
            if (r_v1) begin
                tw_re_o <= r_cos;
                tw_im_o <= r_inv ? r_sin : -r_sin;
            end
        end
    end

endmodule

// File: tb/tb_bel_twiddle_gen.sv
// Scoreboard bench for bel_twiddle_gen: expected twiddles come from real-valued cos/sin,
// a negedge monitor pops and compares every consumed output.
module tb_bel_twiddle_gen;

    localparam int W    = 16;
    localparam int AMPL = 32767;

    typedef struct {
        int re;
        int im;
        int last;
        int tol;
    } exp_t;

    logic          clk_i;
    logic          rst_n_i;
    logic          pipe_halt;
    logic          start_i;
    logic [3:0]    log2_n_i;
    logic [3:0]    stride_log2_i;
    logic          inverse_i;
    logic [W-1:0]  tw_re_o;
    logic [W-1:0]  tw_im_o;
    logic          tw_valid_o;
    logic          busy_o;
    logic          done_o;

    exp_t sb[$];
    exp_t mon_e;
    int   n_err;
    int   n_chk;
    int   n_pop;
    int   n_done;

    bel_twiddle_gen #(.word_width(W), .max_log2(10)) dut (
        .clk_i        (clk_i),
        .rst_n_i      (rst_n_i),
        .pipe_halt    (pipe_halt),
        .start_i      (start_i),
        .log2_n_i     (log2_n_i),
        .stride_log2_i(stride_log2_i),
        .inverse_i    (inverse_i),
        .tw_re_o      (tw_re_o),
        .tw_im_o      (tw_im_o),
        .tw_valid_o   (tw_valid_o),
        .busy_o       (busy_o),
        .done_o       (done_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input int act, input int exp, input int tol);
        n_chk++;
        if (act - exp > tol || exp - act > tol) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (tol %0d) at %0t", name, act, exp, tol, $time);
        end
    endtask

    function automatic int rnd(input real x);
        return (x >= 0.0) ? $rtoi(x + 0.5) : -$rtoi(-x + 0.5);
    endfunction

    // Reference: W_N^k = cos(2*pi*k/N) -/+ j*sin(2*pi*k/N), k = 0, step, ... < N/2
    task automatic push_seq(input int log2n, input int stride, input bit inv);
        exp_t e;
        int   n;
        int   cnt;
        real  ang;
        n   = 1 << log2n;
        cnt = (n / 2) >> stride;
        if (cnt == 0) cnt = 1;
        for (int j = 0; j < cnt; j++) begin
            ang    = 2.0 * 3.14159265358979 * real'(j << stride) / real'(n);
            e.re   = rnd(real'(AMPL) * $cos(ang));
            e.im   = (inv ? 1 : -1) * rnd(real'(AMPL) * $sin(ang));
            e.last = (j == cnt - 1) ? 1 : 0;
            e.tol  = 1;
            sb.push_back(e);
        end
    endtask

    task automatic push_n8_exact(input bit inv);
        int   t_re[4];
        int   t_im[4];
        exp_t e;
        t_re = '{32767, 23170, 0, -23170};
        t_im = '{0, -23170, -32767, -23170};
        for (int j = 0; j < 4; j++) begin
            e.re   = t_re[j];
            e.im   = inv ? -t_im[j] : t_im[j];
            e.last = (j == 3) ? 1 : 0;
            e.tol  = 0;
            sb.push_back(e);
        end
    endtask

    task automatic start_seq(input int log2n, input int stride, input bit inv, input bit rh);
        bit ok;
        ok            = 1'b0;
        log2_n_i      = 4'(log2n);
        stride_log2_i = 4'(stride);
        inverse_i     = inv;
        start_i       = 1'b1;
        for (int t = 0; t < 100; t++) begin
            @(posedge clk_i);
            #1;
            if (busy_o) begin
                ok = 1'b1;
                break;
            end
            if (rh) pipe_halt = ($urandom_range(0, 3) == 0);
        end
        start_i = 1'b0;
        if (!ok) check("start_accept_timeout", 0, 1, 0);
    endtask

    task automatic wait_done(input int bound, input bit rh);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < bound; t++) begin
            @(posedge clk_i);
            #1;
            pipe_halt = rh ? ($urandom_range(0, 3) == 0) : 1'b0;
            if (sb.size() == 0 && !busy_o) begin
                ok = 1'b1;
                break;
            end
        end
        pipe_halt = 1'b0;
        if (!ok) begin
            check("sequence_timeout", sb.size(), 0, 0);
            sb.delete();
        end
    endtask

    task automatic wait_pops(input int target);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk_i);
            #1;
            if (n_pop >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) check("pop_wait_timeout", n_pop, target, 0);
    endtask

    // Monitor: an output is consumed on an edge where tw_valid_o is high and pipe_halt is low
    always @(negedge clk_i) begin
        if (!tw_valid_o) begin
            check("done_without_valid", int'(done_o), 0, 0);
        end else if (!pipe_halt) begin
            if (sb.size() == 0) begin
                check("unexpected_valid", 1, 0, 0);
            end else begin
                mon_e = sb.pop_front();
                check("tw_re", int'($signed(tw_re_o)), mon_e.re, mon_e.tol);
                check("tw_im", int'($signed(tw_im_o)), mon_e.im, mon_e.tol);
                check("done_on_last", int'(done_o), mon_e.last, 0);
                n_pop++;
            end
            if (done_o) n_done++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, errors=%0d", n_err);
        $fatal(1, "watchdog");
    end

    initial begin
        int   base;
        int   d0;
        int   cap_re;
        int   cap_im;
        int   cap_v;
        bit   seen;

        n_err = 0; n_chk = 0; n_pop = 0; n_done = 0;
        rst_n_i = 1'b0; pipe_halt = 1'b0; start_i = 1'b0;
        log2_n_i = '0; stride_log2_i = '0; inverse_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1;
        check("rst_re", int'(tw_re_o), 0, 0);
        check("rst_im", int'(tw_im_o), 0, 0);
        check("rst_valid", int'(tw_valid_o), 0, 0);
        check("rst_busy", int'(busy_o), 0, 0);
        check("rst_done", int'(done_o), 0, 0);
        rst_n_i = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // N=8 forward with exact values and first-valid latency
        push_n8_exact(1'b0);
        start_seq(3, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check("latency_no_valid", int'(tw_valid_o), 0, 0);
        end
        @(negedge clk_i);
        check("latency_valid_t3", int'(tw_valid_o), 1, 0);
        wait_done(50, 1'b0);

        // N=8 inverse
        push_n8_exact(1'b1);
        start_seq(3, 0, 1'b1, 1'b0);
        wait_done(50, 1'b0);

        // N=1024 full stream, stray start mid-run, busy drops after done
        push_seq(10, 0, 1'b0);
        start_seq(10, 0, 1'b0, 1'b0);
        repeat (20) @(posedge clk_i);
        #1 start_i = 1'b1;
        @(posedge clk_i);
        #1 start_i = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 2000; t++) begin
            @(negedge clk_i);
            if (done_o) begin
                seen = 1'b1;
                break;
            end
        end
        check("n1024_done_seen", int'(seen), 1, 0);
        check("busy_with_done", int'(busy_o), 1, 0);
        @(negedge clk_i);
        check("busy_after_done", int'(busy_o), 0, 0);
        check("valid_after_done", int'(tw_valid_o), 0, 0);
        wait_done(50, 1'b0);

        // N=64 stride 2 with a 5-cycle halt after the 3rd valid
        push_seq(6, 2, 1'b0);
        base = n_pop;
        start_seq(6, 2, 1'b0, 1'b0);
        wait_pops(base + 3);
        @(posedge clk_i);
        #1;
        pipe_halt = 1'b1;
        cap_re = int'(tw_re_o);
        cap_im = int'(tw_im_o);
        cap_v  = int'(tw_valid_o);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("halt_re_frozen", int'(tw_re_o), cap_re, 0);
            check("halt_im_frozen", int'(tw_im_o), cap_im, 0);
            check("halt_valid_frozen", int'(tw_valid_o), cap_v, 0);
            check("halt_busy", int'(busy_o), 1, 0);
        end
        @(posedge clk_i);
        #1 pipe_halt = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check("post_halt_no_gap", int'(tw_valid_o), 1, 0);
        end
        wait_done(50, 1'b0);
        check("halt_seq_pops", n_pop - base, 8, 0);

        // Reset mid-sequence, then a clean N=16 sequence
        push_seq(8, 0, 1'b1);
        base = n_pop;
        start_seq(8, 0, 1'b1, 1'b0);
        wait_pops(base + 10);
        d0 = n_done;
        @(posedge clk_i);
        #1 rst_n_i = 1'b0;
        @(posedge clk_i);
        #1;
        sb.delete();
        check("midrst_re", int'(tw_re_o), 0, 0);
        check("midrst_im", int'(tw_im_o), 0, 0);
        check("midrst_valid", int'(tw_valid_o), 0, 0);
        check("midrst_busy", int'(busy_o), 0, 0);
        rst_n_i = 1'b1;
        repeat (5) @(posedge clk_i);
        #1;
        check("midrst_no_done", n_done, d0, 0);
        base = n_pop;
        push_seq(4, 0, 1'b0);
        start_seq(4, 0, 1'b0, 1'b0);
        wait_done(50, 1'b0);
        check("post_rst_pops", n_pop - base, 8, 0);

        // Single-twiddle sequences; start held through the short run is ignored
        base = n_pop;
        push_seq(1, 0, 1'b0);
        start_seq(1, 0, 1'b0, 1'b0);
        wait_done(50, 1'b0);
        push_seq(4, 5, 1'b1);
        start_seq(4, 5, 1'b1, 1'b0);
        start_i = 1'b1;
        repeat (4) @(posedge clk_i);
        #1 start_i = 1'b0;
        wait_done(50, 1'b0);
        repeat (10) @(posedge clk_i);
        #1;
        check("single_seq_pops", n_pop - base, 2, 0);

        // Randomised sequences with random halts
        for (int r = 0; r < 8; r++) begin
            int ln;
            int st;
            bit iv;
            ln = int'($urandom_range(1, 10));
            st = int'($urandom_range(0, 9));
            iv = 1'($urandom_range(0, 1));
            push_seq(ln, st, iv);
            start_seq(ln, st, iv, 1'b1);
            wait_done(4000, 1'b1);
        end
        repeat (10) @(posedge clk_i);
        #1;
        check("final_queue_empty", sb.size(), 0, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
